// File: rtl/spi_burst_ctrl.sv
// Burst controller in front of a byte-level SPI master: TX/RX byte FIFOs plus
// slave-select setup, hold and inter-burst idle sequencing.
module spi_burst_ctrl #(
    parameter int AW       = 4,
    parameter int SS_SETUP = 4,
    parameter int SS_HOLD  = 4,
    parameter int SS_IDLE  = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [7:0] cmd_len_i,
    input  logic       tx_wr_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_full_o,
    output logic       tx_ovf_o,
    input  logic       rx_rd_i,
    output logic [7:0] rx_data_o,
    output logic       rx_empty_o,
    output logic [7:0] spi_din_o,
    output logic       spi_start_o,
    input  logic       spi_done_tick_i,
    input  logic [7:0] spi_dout_i,
    output logic       ss_n_o,
    output logic       busy_o
);
    localparam int            DEPTH    = 2 ** AW;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [7:0]    SETUP_LD = 8'(SS_SETUP - 1);
    localparam logic [7:0]    HOLD_LD  = 8'(SS_HOLD - 1);
    localparam logic [7:0]    IDLE_LD  = 8'(SS_IDLE - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOAD, S_XFER, S_HOLD, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [8:0]      rem_q, rem_d;
    logic            ss_n_q, ss_n_d;
    logic            start_q, start_d;
    logic [7:0]      din_q, din_d;

    logic [7:0]      tx_mem [DEPTH];
    logic [AW-1:0]   tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [AW:0]     tx_count_q, tx_count_d;
    logic            tx_full_q, tx_full_d, tx_ovf_q, tx_ovf_d;

    logic [7:0]      rx_mem [DEPTH];
    logic [AW-1:0]   rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [AW:0]     rx_count_q, rx_count_d;
    logic            rx_empty_q, rx_empty_d;
    logic [7:0]      rx_head_q, rx_head_d;

    logic            load_go, tx_push, tx_pop, rx_push, rx_pop;

    // RX space is checked here so the push at done time always has a free slot.
    assign load_go = (state_q == S_LOAD) && (tx_count_q != '0) && (rx_count_q != CNT_FULL);
    assign tx_pop  = load_go;
    assign tx_push = tx_wr_i && (!tx_full_q || tx_pop);
    assign rx_push = (state_q == S_XFER) && spi_done_tick_i;
    assign rx_pop  = rx_rd_i && !rx_empty_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            ss_n_q      <= 1'b1;
            start_q     <= 1'b0;
            din_q       <= '0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
            tx_full_q   <= 1'b0;
            tx_ovf_q    <= 1'b0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
            rx_empty_q  <= 1'b1;
            rx_head_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            ss_n_q      <= ss_n_d;
            start_q     <= start_d;
            din_q       <= din_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_count_q  <= tx_count_d;
            tx_full_q   <= tx_full_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_count_q  <= rx_count_d;
            rx_empty_q  <= rx_empty_d;
            rx_head_q   <= rx_head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr_ptr_q] <= tx_data_i;
        if (rx_push) rx_mem[rx_wr_ptr_q] <= spi_dout_i;
    end

    // The LOAD cycle supplies the last setup cycle, so SETUP exits one count early.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        unique case (state_q)
            S_IDLE: if (cmd_valid_i) begin
                rem_d   = {1'b0, cmd_len_i} + 9'd1;
                cnt_d   = SETUP_LD;
                state_d = (SS_SETUP > 1) ? S_SETUP : S_LOAD;
            end
            S_SETUP: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: if (load_go) state_d = S_XFER;
            S_XFER: if (spi_done_tick_i) begin
                rem_d = rem_q - 9'd1;
                if (rem_q == 9'd1) begin
                    cnt_d   = HOLD_LD;
                    state_d = S_HOLD;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd0) begin
                    cnt_d   = IDLE_LD;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd0) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ss_n_d  = ss_n_q;
        start_d = 1'b0;
        din_d   = din_q;
        case (state_q)
            S_IDLE: if (cmd_valid_i) ss_n_d = 1'b0;
            S_LOAD: if (load_go) begin
                start_d = 1'b1;
                din_d   = tx_mem[tx_rd_ptr_q];
            end
            S_HOLD: if (cnt_q == 8'd0) ss_n_d = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + PTR_ONE : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + PTR_ONE : tx_rd_ptr_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + CNT_ONE;
            2'b01:   tx_count_d = tx_count_q - CNT_ONE;
            default: tx_count_d = tx_count_q;
        endcase
        tx_full_d = (tx_count_d == CNT_FULL);
        tx_ovf_d  = tx_ovf_q | (tx_wr_i & ~tx_push);

        rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + PTR_ONE : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + PTR_ONE : rx_rd_ptr_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + CNT_ONE;
            2'b01:   rx_count_d = rx_count_q - CNT_ONE;
            default: rx_count_d = rx_count_q;
        endcase
        rx_empty_d = (rx_count_d == '0);
        // Show-ahead head register; bypass when the new head is the byte being pushed.
        if (rx_count_d == '0)
            rx_head_d = rx_head_q;
        else if (rx_push && (rx_wr_ptr_q == rx_rd_ptr_d))
            rx_head_d = spi_dout_i;
        else
            rx_head_d = rx_mem[rx_rd_ptr_d];
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign ss_n_o      = ss_n_q;
    assign spi_start_o = start_q;
    assign spi_din_o   = din_q;
    assign tx_full_o   = tx_full_q;
    assign tx_ovf_o    = tx_ovf_q;
    assign rx_empty_o  = rx_empty_q;
    assign rx_data_o   = rx_head_q;
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench for spi_burst_ctrl with a simple SPI slave model that answers
// each start with a done tick two cycles later.
module tb_spi_burst_ctrl;
    logic       clk;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_len;
    logic       tx_wr, tx_full, tx_ovf;
    logic [7:0] tx_data;
    logic       rx_rd, rx_empty;
    logic [7:0] rx_data;
    logic [7:0] spi_din, spi_dout;
    logic       spi_start, spi_done;
    logic       ss_n, busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    spi_burst_ctrl dut (
        .clk_i(clk), .rst_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_len_i(cmd_len),
        .tx_wr_i(tx_wr), .tx_data_i(tx_data), .tx_full_o(tx_full), .tx_ovf_o(tx_ovf),
        .rx_rd_i(rx_rd), .rx_data_o(rx_data), .rx_empty_o(rx_empty),
        .spi_din_o(spi_din), .spi_start_o(spi_start),
        .spi_done_tick_i(spi_done), .spi_dout_i(spi_dout),
        .ss_n_o(ss_n), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: cyc at a negedge equals the index of the edge that produced the outputs.
    int         start_cnt = 0, rise_cnt = 0;
    int         last_start = 0, last_fall = 0, last_rise = 0, busy_fall = 0;
    logic [7:0] mosi_q[$];
    logic       prev_ss = 1'b1, prev_busy = 1'b0;
    initial forever begin
        @(negedge clk);
        if (spi_start) begin
            start_cnt++;
            last_start = cyc;
            mosi_q.push_back(spi_din);
        end
        if (prev_ss && !ss_n) last_fall = cyc;
        if (!prev_ss && ss_n) begin
            last_rise = cyc;
            rise_cnt++;
        end
        if (prev_busy && !busy) busy_fall = cyc;
        prev_ss   = ss_n;
        prev_busy = busy;
    end

    logic [7:0] resp_q[$];
    int         done_edge = 0;
    initial begin
        spi_done = 1'b0;
        spi_dout = 8'h00;
        forever begin
            @(negedge clk);
            if (spi_start) begin
                @(negedge clk);
                spi_done = 1'b1;
                if (resp_q.size() > 0) spi_dout = resp_q.pop_front();
                else                   spi_dout = 8'hEE;
                done_edge = cyc + 1;
                $display("spi xfer: mosi=%02h miso=%02h", spi_din, spi_dout);
                @(negedge clk);
                spi_done = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_wr   = 1'b1;
        tx_data = b;
        step(1);
        tx_wr   = 1'b0;
    endtask

    task automatic pop_rx(output logic [7:0] b);
        b     = rx_data;
        rx_rd = 1'b1;
        step(1);
        rx_rd = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] len);
        cmd_valid = 1'b1;
        cmd_len   = len;
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (busy && k < budget) begin
            step(1);
            k++;
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: busy_o=%b after %0d cycles, required 0", name, busy, budget);
        end
    endtask

    task automatic wait_starts(input int target, input int budget, input string name);
        int k = 0;
        while (start_cnt < target && k < budget) begin
            step(1);
            k++;
        end
        n_chk++;
        if (start_cnt < target) begin
            n_fail++;
            $display("FAIL %s: start count %0d, required %0d", name, start_cnt, target);
        end
    endtask

    task automatic test_reset();
        logic [6:0] flags;
        #1 rst_n = 1'b0;
        step(3);
        flags = {ss_n, spi_start, cmd_ready, busy, tx_full, rx_empty, tx_ovf};
        n_chk++;
        if (flags !== 7'b1010010) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 1010010", flags);
        end
        n_chk++;
        if (spi_din !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_din: got %h required 00", spi_din);
        end
        n_chk++;
        if (rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rx_data: got %h required 00", rx_data);
        end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_single_byte();
        int         s0 = start_cnt;
        logic [7:0] b;
        mosi_q.delete();
        resp_q.push_back(8'h3C);
        push_tx(8'hA5);
        send_cmd(8'd0);
        wait_idle(100, "single_idle");
        n_chk++;
        if (start_cnt - s0 != 1 || mosi_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_starts: got %0d starts required 1", start_cnt - s0);
        end else begin
            n_chk++;
            if (mosi_q[0] !== 8'hA5) begin
                n_fail++;
                $display("FAIL single_mosi: got %h required a5", mosi_q[0]);
            end
        end
        n_chk++;
        if (last_start - last_fall != 4) begin
            n_fail++;
            $display("FAIL single_setup: got %0d cycles required 4", last_start - last_fall);
        end
        n_chk++;
        if (last_rise - done_edge != 4) begin
            n_fail++;
            $display("FAIL single_hold: got %0d cycles required 4", last_rise - done_edge);
        end
        n_chk++;
        if (busy_fall - last_rise != 8) begin
            n_fail++;
            $display("FAIL single_gap: got %0d cycles required 8", busy_fall - last_rise);
        end
        n_chk++;
        if (rx_empty !== 1'b0 || rx_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL single_rx: got empty=%b data=%h required empty=0 data=3c", rx_empty, rx_data);
        end
        pop_rx(b);
        n_chk++;
        if (rx_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL single_rx_drain: got empty=%b required 1", rx_empty);
        end
    endtask

    task automatic test_burst();
        int         s0 = start_cnt;
        int         r0 = rise_cnt;
        logic [7:0] b;
        mosi_q.delete();
        for (int i = 0; i < 4; i++) begin
            resp_q.push_back(8'(8'hC1 + i));
            push_tx(8'(i + 1));
        end
        send_cmd(8'd3);
        wait_idle(200, "burst_idle");
        n_chk++;
        if (start_cnt - s0 != 4 || rise_cnt - r0 != 1) begin
            n_fail++;
            $display("FAIL burst_framing: got starts=%0d ss_rises=%0d required 4 and 1",
                     start_cnt - s0, rise_cnt - r0);
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (i >= mosi_q.size() || mosi_q[i] !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL burst_mosi[%0d]: got %h required %h", i,
                         (i < mosi_q.size()) ? mosi_q[i] : 8'hxx, 8'(i + 1));
            end
        end
        for (int i = 0; i < 4; i++) begin
            pop_rx(b);
            n_chk++;
            if (b !== 8'(8'hC1 + i)) begin
                n_fail++;
                $display("FAIL burst_rx[%0d]: got %h required %h", i, b, 8'(8'hC1 + i));
            end
        end
    endtask

    task automatic test_underrun();
        int         s0 = start_cnt;
        int         wcyc;
        logic [7:0] b;
        mosi_q.delete();
        resp_q.push_back(8'hD1);
        resp_q.push_back(8'hD2);
        resp_q.push_back(8'hD3);
        push_tx(8'h11);
        send_cmd(8'd2);
        wait_starts(s0 + 1, 50, "underrun_first");
        step(50);
        n_chk++;
        if (start_cnt - s0 != 1 || ss_n !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_stall: got starts=%0d ss_n=%b busy=%b required 1 0 1",
                     start_cnt - s0, ss_n, busy);
        end
        wcyc = cyc + 1;
        push_tx(8'h77);
        wait_starts(s0 + 2, 10, "underrun_resume");
        n_chk++;
        if (last_start - wcyc < 1 || last_start - wcyc > 2) begin
            n_fail++;
            $display("FAIL underrun_latency: got %0d cycles required 1..2", last_start - wcyc);
        end
        push_tx(8'h78);
        wait_idle(100, "underrun_idle");
        n_chk++;
        if (mosi_q.size() != 3 || mosi_q[1] !== 8'h77 || mosi_q[2] !== 8'h78) begin
            n_fail++;
            $display("FAIL underrun_mosi: got %0d bytes required 3 ending 77 78", mosi_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            pop_rx(b);
            n_chk++;
            if (b !== 8'(8'hD1 + i)) begin
                n_fail++;
                $display("FAIL underrun_rx[%0d]: got %h required %h", i, b, 8'(8'hD1 + i));
            end
        end
    endtask

    task automatic test_rx_backpressure();
        int         s1;
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            resp_q.push_back(8'(8'h80 + i));
            push_tx(8'(i));
        end
        send_cmd(8'd15);
        wait_idle(300, "bp_fill_idle");
        resp_q.push_back(8'hA1);
        resp_q.push_back(8'hA2);
        push_tx(8'h31);
        push_tx(8'h32);
        s1 = start_cnt;
        send_cmd(8'd1);
        step(30);
        n_chk++;
        if (start_cnt != s1 || ss_n !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall: got starts=%0d ss_n=%b required 0 starts, ss_n=0",
                     start_cnt - s1, ss_n);
        end
        pop_rx(b);
        n_chk++;
        if (b !== 8'h80) begin
            n_fail++;
            $display("FAIL bp_rx_first: got %h required 80", b);
        end
        step(30);
        n_chk++;
        if (start_cnt - s1 != 1) begin
            n_fail++;
            $display("FAIL bp_release_one: got %0d starts required 1", start_cnt - s1);
        end
        pop_rx(b);
        wait_idle(100, "bp_idle");
        n_chk++;
        if (start_cnt - s1 != 2) begin
            n_fail++;
            $display("FAIL bp_release_two: got %0d starts required 2", start_cnt - s1);
        end
        for (int i = 2; i < 18; i++) begin
            logic [7:0] exp;
            exp = (i < 16) ? 8'(8'h80 + i) : 8'(8'hA1 + (i - 16));
            pop_rx(b);
            n_chk++;
            if (b !== exp) begin
                n_fail++;
                $display("FAIL bp_rx[%0d]: got %h required %h", i, b, exp);
            end
        end
        n_chk++;
        if (rx_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_rx_empty: got %b required 1", rx_empty);
        end
    endtask

    task automatic test_overflow();
        int         s0;
        logic [7:0] b;
        for (int i = 0; i < 16; i++) push_tx(8'(8'h40 + i));
        n_chk++;
        if (tx_full !== 1'b1 || tx_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_16: got full=%b ovf=%b required 1 0", tx_full, tx_ovf);
        end
        push_tx(8'h50);
        n_chk++;
        if (tx_full !== 1'b1 || tx_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_17: got full=%b ovf=%b required 1 1", tx_full, tx_ovf);
        end
        s0 = start_cnt;
        mosi_q.delete();
        send_cmd(8'd15);
        wait_idle(300, "ovf_idle");
        n_chk++;
        if (start_cnt - s0 != 16 || mosi_q.size() != 16) begin
            n_fail++;
            $display("FAIL ovf_starts: got %0d required 16", start_cnt - s0);
        end
        for (int i = 0; i < 16; i++) begin
            n_chk++;
            if (i >= mosi_q.size() || mosi_q[i] !== 8'(8'h40 + i)) begin
                n_fail++;
                $display("FAIL ovf_mosi[%0d]: required %h", i, 8'(8'h40 + i));
            end
        end
        for (int i = 0; i < 16; i++) pop_rx(b);
        n_chk++;
        if (rx_empty !== 1'b1 || tx_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got rx_empty=%b ovf=%b required 1 1", rx_empty, tx_ovf);
        end
    endtask

    task automatic test_reset_mid_burst();
        int         s0 = start_cnt;
        logic [7:0] b;
        resp_q.delete();
        for (int i = 0; i < 4; i++) push_tx(8'(i + 1));
        send_cmd(8'd3);
        wait_starts(s0 + 2, 50, "rst_mid_second");
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (ss_n !== 1'b1 || spi_start !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got ss_n=%b start=%b busy=%b required 1 0 0",
                     ss_n, spi_start, busy);
        end
        n_chk++;
        if (rx_empty !== 1'b1 || tx_full !== 1'b0 || tx_ovf !== 1'b0 || rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid_fifos: got rx_empty=%b tx_full=%b ovf=%b rx_data=%h required 1 0 0 00",
                     rx_empty, tx_full, tx_ovf, rx_data);
        end
        step(3);
        resp_q.delete();
        rst_n = 1'b1;
        step(2);
        mosi_q.delete();
        resp_q.push_back(8'h5B);
        push_tx(8'h99);
        send_cmd(8'd0);
        wait_idle(100, "rst_mid_new_idle");
        n_chk++;
        if (mosi_q.size() != 1 || mosi_q[0] !== 8'h99) begin
            n_fail++;
            $display("FAIL rst_mid_new_mosi: got %0d bytes required one byte 99", mosi_q.size());
        end
        n_chk++;
        if (rx_empty !== 1'b0 || rx_data !== 8'h5B) begin
            n_fail++;
            $display("FAIL rst_mid_new_rx: got empty=%b data=%h required 0 5b", rx_empty, rx_data);
        end
        pop_rx(b);
    endtask

    initial begin
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = 8'h00;
        tx_wr     = 1'b0;
        tx_data   = 8'h00;
        rx_rd     = 1'b0;
        test_reset();
        test_single_byte();
        test_burst();
        test_underrun();
        test_rx_backpressure();
        test_overflow();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
